// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for a Memory256x16-style port (req/rsp valid-ready).
// Optional write-verify readback enabled by defining WR_VERIFY_EN.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [1:0] RD_CNT = 2'(RD_LAT);

  state_t     state, state_nxt;
  logic [1:0] cnt;
  logic       rd_done;

  assign rd_done = (state == READ) && (cnt == 2'd0);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_we ? WRITE : READ;
      end
      WRITE: begin
        mem_we = 1'b1;
`ifdef WR_VERIFY_EN
        state_nxt = READ;
`else
        state_nxt = RESP;
`endif
      end
      READ: begin
        if (cnt == 2'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Address and data are captured only on the accept edge and then held for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_din   <= '0;
      cnt       <= 2'd0;
      rsp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        mem_addr <= req_addr;
        mem_din  <= req_wdata;
      end
      if (state_nxt == READ && state != READ) cnt <= RD_CNT;
      else if (state == READ && cnt != 2'd0)  cnt <= cnt - 2'd1;
`ifndef WR_VERIFY_EN
      if (state == WRITE) rsp_rdata <= '0;
`endif
      if (rd_done) rsp_rdata <= mem_dout;
    end
  end

`ifdef WR_VERIFY_EN
  logic is_store;

  // Loads always leave rsp_err clear; only a store's readback is compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) is_store <= req_we;
      if (rd_done) rsp_err <= is_store && (mem_dout != mem_din);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, corner sequences, random traffic vs reference.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_we;

  int n_vec = 0, n_err = 0;

`ifdef WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LD_LAT = 3;
  localparam int ST_LAT = VERIFY ? 4 : 2;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory device: registered read, optional bit-0 stuck-at-0 fault.
  logic [15:0] mem [256];
  logic        stuck0 = 1'b0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din & (stuck0 ? 16'hFFFE : 16'hFFFF);
    mem_dout <= mem[mem_addr];
  end

  // Transaction-level reference: what each address should contain.
  logic [15:0] ref_mem [256];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                           input int stall, output logic [15:0] rd, output logic er,
                           output int lat, output int wes, output int busy_bad);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    busy_bad = req_ready ? 0 : 1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 8'($urandom); req_wdata = 16'($urandom);
    lat = 0; wes = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_we) wes++;
      if (rsp_valid) break;
      if (req_ready) busy_bad++;
    end
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (mem_we || req_ready || !rsp_valid || rsp_rdata !== rd || rsp_err !== er) busy_bad++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    if (rsp_valid) busy_bad++;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
    int          stall;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t        vt [9];
  logic [15:0] rd;
  logic        er;
  int          lat, wes, bb;
  int          acc [$];

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    vt[0] = '{1'b1, 8'h10, 16'hAAAA, 0, VERIFY ? 16'hAAAA : 16'h0, ST_LAT};
    vt[1] = '{1'b0, 8'h10, 16'h0,    0, 16'hAAAA, LD_LAT};
    vt[2] = '{1'b1, 8'h00, 16'h1111, 0, VERIFY ? 16'h1111 : 16'h0, ST_LAT};
    vt[3] = '{1'b1, 8'h01, 16'hBBBB, 1, VERIFY ? 16'hBBBB : 16'h0, ST_LAT};
    vt[4] = '{1'b1, 8'hFF, 16'hCCCC, 0, VERIFY ? 16'hCCCC : 16'h0, ST_LAT};
    vt[5] = '{1'b0, 8'hFF, 16'h0,    0, 16'hCCCC, LD_LAT};
    vt[6] = '{1'b0, 8'h01, 16'h0,    2, 16'hBBBB, LD_LAT};
    vt[7] = '{1'b0, 8'h00, 16'h0,    0, 16'h1111, LD_LAT};
    vt[8] = '{1'b0, 8'h10, 16'h0,    5, 16'hAAAA, LD_LAT};

    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    foreach (vt[i]) begin
      do_access(vt[i].we, vt[i].a, vt[i].d, vt[i].stall, rd, er, lat, wes, bb);
      if (vt[i].we) ref_mem[vt[i].a] = vt[i].d;
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), er, 0);
      check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d_we_cycles", i), wes, vt[i].we ? 1 : 0);
      check($sformatf("vec%0d_handshake", i), bb, 0);
    end

    // Reset asserted during the second READ cycle abandons the load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    bb = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) bb++; end
    check("midrst_no_rsp", bb, 0);
    do_access(1'b0, 8'h10, 16'h0, 0, rd, er, lat, wes, bb);
    check("postrst_rdata", rd, 16'hAAAA);
    check("postrst_lat", lat, LD_LAT);

    // Back-to-back loads with rsp_ready held: one accept every LD_LAT+1 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b1;
    acc.delete();
    for (int c = 0; c < 16; c++) begin
      if (req_ready) acc.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    check("tput_accepts", acc.size(), 4);
    if (acc.size() >= 3) begin
      check("tput_gap0", acc[1] - acc[0], LD_LAT + 1);
      check("tput_gap1", acc[2] - acc[1], LD_LAT + 1);
    end

`ifdef WR_VERIFY_EN
    stuck0 = 1'b1;
    do_access(1'b1, 8'h80, 16'h0001, 0, rd, er, lat, wes, bb);
    check("vfy_err_bad", er, 1);
    check("vfy_rdata_bad", rd, 16'h0000);
    do_access(1'b1, 8'h80, 16'h0002, 0, rd, er, lat, wes, bb);
    check("vfy_err_ok", er, 0);
    check("vfy_rdata_ok", rd, 16'h0002);
    check("vfy_lat", lat, ST_LAT);
    stuck0 = 1'b0;
    ref_mem[8'h80] = 16'h0002;
`endif

    for (int n = 0; n < 150; n++) begin
      logic        w;
      logic [7:0]  a;
      logic [15:0] d, exp_rd;
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7) | 8'hF8 * 8'($urandom_range(0, 1)));
      d = 16'($urandom);
      exp_rd = w ? (VERIFY ? d : 16'h0) : ref_mem[a];
      do_access(w, a, d, $urandom_range(0, 3), rd, er, lat, wes, bb);
      if (w) ref_mem[a] = d;
      check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      check($sformatf("rnd%0d_lat", n), lat, w ? ST_LAT : LD_LAT);
      check($sformatf("rnd%0d_err", n), er, 0);
      check($sformatf("rnd%0d_we", n), wes, w ? 1 : 0);
      check($sformatf("rnd%0d_hs", n), bb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // mem_we must never be high for two consecutive cycles.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (prev_we && mem_we) begin
      n_err++;
      $display("FAIL mem_we_double: got 1 expected 0");
    end
    prev_we = mem_we;
  end

endmodule
